vga_scan_engine: RTL and testbench
==================================

VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

Interface
REQ-001 Clk  input  1  system clock, 50 MHz; the only clock in the block.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 R_in, G_in, B_in  input  8 each  pixel colour from color mapper, valid for the current DrawX/DrawY.
REQ-004 DrawX  output  10  current pixel column (0-799).
REQ-005 DrawY  output  10  current pixel row (0-524).
REQ-006 pix_en  output  1  one-Clk pulse marking each pixel tick (every second Clk).
REQ-007 frame_start  output  1  one-Clk pulse on the pix_en cycle where (DrawX,DrawY) becomes (0,0).
REQ-008 VGA_CLK  output  1  25 MHz pixel clock for the DAC, equal to the inverse of pix_en phase.
REQ-009 VGA_HS, VGA_VS  output  1 each  horizontal/vertical sync, active low, registered.
REQ-010 VGA_BLANK_N  output  1  low outside the visible area, registered.
REQ-011 VGA_SYNC_N  output  1  tied 0 (sync-on-green unused).
REQ-012 VGA_R, VGA_G, VGA_B  output  8 each  registered pixel colour to the DAC.

Function
REQ-013 pix_en SHALL toggle every Clk, giving a 25 MHz tick rate; hc/vc counters SHALL advance only on cycles with pix_en=1.
REQ-014 The horizontal counter SHALL count 0..799 and wrap to 0; the vertical counter SHALL increment only on that horizontal wrap.
REQ-015 The vertical counter SHALL count 0..524 and wrap to 0 when both counters wrap together.
REQ-016 DrawX/DrawY SHALL equal the hc/vc counters directly, with no added latency.
REQ-017 The horizontal visible region SHALL be hc 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-018 The vertical visible region SHALL be vc 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-019 The block SHALL decode sync and visible from the current counters, then register them on the pix_en cycle.
REQ-020 VGA_HS SHALL be 0 iff registered hc is in 656-751, and VGA_VS SHALL be 0 iff registered vc is in 490-491.
REQ-021 VGA_R/G/B SHALL register R_in/G_in/B_in on the same pix_en cycle when the counters are visible, and register 0 otherwise.
REQ-022 HS, VS, BLANK_N and RGB SHALL share exactly one pixel tick of latency relative to DrawX/DrawY.
REQ-023 Registered outputs SHALL hold their value on Clk cycles where pix_en=0.
REQ-024 frame_start SHALL assert on the single pix_en cycle where hc=799 and vc=524.
REQ-025 frame_start SHALL remain 0 on every other cycle, including the first tick after reset.
REQ-026 Colour inputs SHALL be ignored and never propagated while blanked.

Reset
REQ-027 While Reset=1, the block SHALL hold hc=0, vc=0 and pix_en=0.
REQ-028 While Reset=1, the block SHALL hold VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0 and frame_start=0.
REQ-029 Reset asserted mid-frame SHALL force the reset values immediately, without waiting for a clock edge.
REQ-030 After Reset deasserts, the first pix_en pulse SHALL occur on the second rising Clk edge.
REQ-031 After Reset deasserts, scanning SHALL restart at (0,0).

Structure
REQ-032 A shared package vga_timing_pkg SHALL hold the constants H_VISIBLE=640, H_FP_END=656, H_SYNC_END=752, H_TOTAL=800.
REQ-033 vga_timing_pkg SHALL hold the constants V_VISIBLE=480, V_FP_END=490, V_SYNC_END=492, V_TOTAL=525.
REQ-034 vga_timing_pkg SHALL hold an rgb24_t packed struct type.
REQ-035 One sub-module, scan_counter, SHALL be instantiated twice (horizontal, vertical), each with an enable, terminal-count parameter, count output and wrap output.

Verification
REQ-036 Release reset and count Clk edges -> pix_en first high on edge 2, then every 2nd edge; DrawX=0, DrawY=0 until that first tick.
REQ-037 Run one line -> VGA_HS low for exactly 96 ticks, starting one tick after DrawX=656; DrawX wraps 799->0 and DrawY increments by 1.
REQ-038 Run a full frame -> 420000 ticks between frame_start pulses; VGA_VS low for 2 lines, starting one tick after DrawY=490.
REQ-039 Drive R_in=8'hAA, G_in=8'h55, B_in=8'h0F constantly -> VGA_RGB shows AA/55/0F one tick after DrawX 0..639; RGB=0 and BLANK_N=0 for DrawX>=640 and for DrawY>=480.
REQ-040 Assert Reset at DrawX=300, DrawY=200 between clock edges -> outputs take reset values immediately; scanning resumes at (0,0) after release.
REQ-041 Check the corner (799,524) -> frame_start high for exactly one Clk; the next tick shows DrawX=0, DrawY=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, pixel colour type and region decode helpers
// shared by the scan engine and its counters.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam logic [9:0] H_VISIBLE  = 10'd640;
  localparam logic [9:0] H_FP_END   = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd752;
  localparam logic [9:0] H_TOTAL    = 10'd800;

  localparam logic [9:0] V_VISIBLE  = 10'd480;
  localparam logic [9:0] V_FP_END   = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd492;
  localparam logic [9:0] V_TOTAL    = 10'd525;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  function automatic logic in_h_sync(input logic [9:0] h);
    return (h >= H_FP_END) && (h < H_SYNC_END);
  endfunction

  function automatic logic in_v_sync(input logic [9:0] v);
    return (v >= V_FP_END) && (v < V_SYNC_END);
  endfunction

  function automatic logic is_visible(input logic [9:0] h, input logic [9:0] v);
    return (h < H_VISIBLE) && (v < V_VISIBLE);
  endfunction

endpackage

// File: rtl/vga_scan_engine_if.sv
// Pixel-side bus of the scan engine: colour request/response plus DAC outputs.
// master = scan engine, slave = colour mapper / DAC side.
interface vga_scan_engine_if;

  logic [7:0] R_in;
  logic [7:0] G_in;
  logic [7:0] B_in;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pix_en;
  logic       frame_start;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (
    input  R_in, G_in, B_in,
    output DrawX, DrawY, pix_en, frame_start, VGA_CLK,
    output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output R_in, G_in, B_in,
    input  DrawX, DrawY, pix_en, frame_start, VGA_CLK,
    input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );

endinterface

// File: rtl/scan_counter.sv
// Enabled modulo-(TC+1) counter; wrap is combinational and high on the enabled
// cycle where the count sits at TC. No latency on cnt, no backpressure.
module scan_counter #(
  parameter int             W  = 10,
  parameter logic [W-1:0]   TC = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap  = en && (cnt_q == TC);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_scan_engine.sv
// 640x480 VGA raster generator: half-rate pixel tick, DrawX/DrawY with no delay,
// sync/blank/RGB registered one pixel tick behind the counters; never stalls.
module vga_scan_engine
  import vga_timing_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  vga_scan_engine_if.master vga
);

  logic       started_q, started_d;
  logic       pix_en_q, pix_en_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_n_q, blank_n_d;
  rgb24_t     rgb_q, rgb_d;
  rgb24_t     rgb_in;
  logic [9:0] hc, vc;
  logic       h_wrap, v_wrap;
  logic       visible;

  scan_counter #(.W(CNT_W), .TC(H_TOTAL - 10'd1)) u_hc (
    .clk (Clk),
    .rst (Reset),
    .en  (pix_en_q),
    .cnt (hc),
    .wrap(h_wrap)
  );

  scan_counter #(.W(CNT_W), .TC(V_TOTAL - 10'd1)) u_vc (
    .clk (Clk),
    .rst (Reset),
    .en  (h_wrap),
    .cnt (vc),
    .wrap(v_wrap)
  );

  assign rgb_in  = '{r: vga.R_in, g: vga.G_in, b: vga.B_in};
  assign visible = is_visible(hc, vc);

  // started_q holds off the first tick by one edge so it lands on edge 2 after reset.
  always_comb begin
    started_d = 1'b1;
    pix_en_d  = started_q & ~pix_en_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (pix_en_q) begin
      hs_d      = ~in_h_sync(hc);
      vs_d      = ~in_v_sync(vc);
      blank_n_d = visible;
      rgb_d     = visible ? rgb_in : '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      started_q <= 1'b0;
      pix_en_q  <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      started_q <= started_d;
      pix_en_q  <= pix_en_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.pix_en      = pix_en_q;
  // v_wrap is exactly the tick at (799,524), i.e. the tick that rolls over to (0,0).
  assign vga.frame_start = v_wrap;
  assign vga.VGA_CLK     = ~pix_en_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_R       = rgb_q.r;
  assign vga.VGA_G       = rgb_q.g;
  assign vga.VGA_B       = rgb_q.b;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine: frame-position model (pixel tick count -> x,y) checked
// every negedge, plus literal checks on reset, line/frame boundaries and async reset.
module tb_vga_scan_engine;

  localparam int H_TOT = 800;
  localparam int V_TOT = 525;
  localparam int FRAME = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_scan_engine_if vif();

  vga_scan_engine dut (
    .Clk  (clk),
    .Reset(rst),
    .vga  (vif)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          n = 0;          // rising edges since reset release
  int          k = 0;          // current frame position (ticks since (0,0))
  int          prev_pos = 0;   // position decoded by the last tick
  bit          have_tick = 1'b0;
  logic [23:0] last_in = '0;
  bit          const_col = 1'b1;
  int          hs_low_cnt = 0;
  int          vs_low_cnt = 0;
  int          fs_cnt = 0;
  logic [9:0]  force_val = '0;

  function automatic bit model_pix_en();
    return (n >= 2) && (n % 2 == 0);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n = 0;
        k = 0;
        have_tick = 1'b0;
      end else begin
        if (model_pix_en()) begin
          last_in   = {vif.R_in, vif.G_in, vif.B_in};
          prev_pos  = k;
          k         = (k + 1) % FRAME;
          have_tick = 1'b1;
        end
        n++;
      end
    end
  endtask

  task automatic compare_loop();
    logic [50:0] obs, expv;
    logic        pe, ehs, evs, ebl, efs;
    logic [23:0] ergb;
    int          px, py;
    forever begin
      @(negedge clk);
      pe  = model_pix_en();
      efs = pe && (k == FRAME - 1);
      ehs = 1'b1; evs = 1'b1; ebl = 1'b0; ergb = '0;
      if (have_tick) begin
        px   = prev_pos % H_TOT;
        py   = prev_pos / H_TOT;
        ehs  = !(px >= 656 && px < 752);
        evs  = !(py == 490 || py == 491);
        ebl  = (px < 640) && (py < 480);
        ergb = ebl ? last_in : 24'h0;
      end
      obs  = {vif.DrawX, vif.DrawY, vif.pix_en, vif.VGA_CLK, vif.frame_start, vif.VGA_HS,
              vif.VGA_VS, vif.VGA_BLANK_N, vif.VGA_SYNC_N, vif.VGA_R, vif.VGA_G, vif.VGA_B};
      expv = {10'(k % H_TOT), 10'(k / H_TOT), pe, ~pe, efs, ehs, evs, ebl, 1'b0, ergb};
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL scan t=%0t got x=%0d y=%0d pe=%b vclk=%b fs=%b hs=%b vs=%b bl=%b sn=%b rgb=%h expected x=%0d y=%0d pe=%b vclk=%b fs=%b hs=%b vs=%b bl=%b sn=%b rgb=%h",
                 $time, obs[50:41], obs[40:31], obs[30], obs[29], obs[28], obs[27], obs[26], obs[25], obs[24], obs[23:0],
                 expv[50:41], expv[40:31], expv[30], expv[29], expv[28], expv[27], expv[26], expv[25], expv[24], expv[23:0]);
      end
      if (!rst && vif.pix_en && !vif.VGA_HS) hs_low_cnt++;
      if (!rst && vif.pix_en && !vif.VGA_VS) vs_low_cnt++;
      if (vif.frame_start) fs_cnt++;
    end
  endtask

  task automatic colour_loop();
    forever begin
      @(posedge clk);
      #2;
      if (const_col) {vif.R_in, vif.G_in, vif.B_in} = 24'hAA550F;
      else           {vif.R_in, vif.G_in, vif.B_in} = 24'($urandom);
    end
  endtask

  // Advance (at posedge+2) until the model sits at (x,y), then confirm the DUT agrees.
  task automatic run_to(input int x, input int y);
    int budget = 20000;
    while (k != y * H_TOT + x && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    chk($sformatf("reach_x(%0d,%0d)", x, y), int'(vif.DrawX), x);
    chk($sformatf("reach_y(%0d,%0d)", x, y), int'(vif.DrawY), y);
  endtask

  // Move the vertical counter (and the model) to line y while mid-line.
  task automatic jump_line(input int y);
    int budget = 4000;
    while (!((k % H_TOT) >= 10 && (k % H_TOT) < 600) && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    force_val = 10'(y);
    k = y * H_TOT + (k % H_TOT);
    force dut.u_vc.cnt_q = force_val;
    @(posedge clk);
    #2;
    release dut.u_vc.cnt_q;
  endtask

  initial begin
    int vs_base, fs_base;
    {vif.R_in, vif.G_in, vif.B_in} = 24'hAA550F;
    fork
      model_loop();
      compare_loop();
      colour_loop();
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk("rst_pix_en", int'(vif.pix_en), 0);
    chk("rst_hs", int'(vif.VGA_HS), 1);
    chk("rst_vs", int'(vif.VGA_VS), 1);
    chk("rst_blank", int'(vif.VGA_BLANK_N), 0);
    chk("rst_rgb", int'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 0);
    rst = 1'b0;

    @(posedge clk); #2;
    chk("edge1_pix_en", int'(vif.pix_en), 0);
    @(posedge clk); #2;
    chk("edge2_pix_en", int'(vif.pix_en), 1);
    chk("edge2_drawx", int'(vif.DrawX), 0);
    chk("first_tick_fs", int'(vif.frame_start), 0);
    @(posedge clk); #2;
    chk("edge3_pix_en", int'(vif.pix_en), 0);
    chk("edge3_drawx", int'(vif.DrawX), 1);
    chk("edge3_rgb", int'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 32'hAA550F);
    chk("edge3_blank", int'(vif.VGA_BLANK_N), 1);
    @(posedge clk); #2;
    chk("edge4_pix_en", int'(vif.pix_en), 1);

    run_to(640, 0);
    chk("x639_blank", int'(vif.VGA_BLANK_N), 1);
    chk("x639_rgb", int'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 32'hAA550F);
    run_to(641, 0);
    chk("x640_blank", int'(vif.VGA_BLANK_N), 0);
    chk("x640_rgb", int'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 0);
    run_to(656, 0);
    chk("x655_hs", int'(vif.VGA_HS), 1);
    run_to(657, 0);
    chk("x656_hs", int'(vif.VGA_HS), 0);
    run_to(752, 0);
    chk("x751_hs", int'(vif.VGA_HS), 0);
    run_to(753, 0);
    chk("x752_hs", int'(vif.VGA_HS), 1);
    const_col = 1'b0;
    run_to(0, 1);
    run_to(100, 2);
    chk("hs_low_ticks_2_lines", hs_low_cnt, 192);

    jump_line(478);
    run_to(5, 479);
    chk("y479_blank", int'(vif.VGA_BLANK_N), 1);
    run_to(5, 480);
    chk("y480_blank", int'(vif.VGA_BLANK_N), 0);
    chk("y480_rgb", int'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 0);

    vs_base = vs_low_cnt;
    jump_line(489);
    run_to(0, 490);
    chk("y489_end_vs", int'(vif.VGA_VS), 1);
    run_to(1, 490);
    chk("y490_vs", int'(vif.VGA_VS), 0);
    run_to(10, 493);
    chk("vs_low_ticks", vs_low_cnt - vs_base, 1600);

    fs_base = fs_cnt;
    jump_line(523);
    run_to(799, 524);
    chk("corner_fs_pre", int'(vif.frame_start), 0);
    @(posedge clk); #2;
    chk("corner_fs", int'(vif.frame_start), 1);
    chk("corner_x", int'(vif.DrawX), 799);
    @(posedge clk); #2;
    chk("wrap_fs", int'(vif.frame_start), 0);
    chk("wrap_x", int'(vif.DrawX), 0);
    chk("wrap_y", int'(vif.DrawY), 0);
    run_to(20, 0);
    chk("fs_pulse_count", fs_cnt - fs_base, 1);

    jump_line(200);
    run_to(300, 200);
    chk("pre_rst_blank", int'(vif.VGA_BLANK_N), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_x", int'(vif.DrawX), 0);
    chk("async_rst_y", int'(vif.DrawY), 0);
    chk("async_rst_pix_en", int'(vif.pix_en), 0);
    chk("async_rst_hs", int'(vif.VGA_HS), 1);
    chk("async_rst_vs", int'(vif.VGA_VS), 1);
    chk("async_rst_blank", int'(vif.VGA_BLANK_N), 0);
    chk("async_rst_rgb", int'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("rel_edge1_pix_en", int'(vif.pix_en), 0);
    @(posedge clk); #2;
    chk("rel_edge2_pix_en", int'(vif.pix_en), 1);
    chk("rel_x", int'(vif.DrawX), 0);
    chk("rel_y", int'(vif.DrawY), 0);
    run_to(3, 0);
    repeat (20) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
